pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Pipeline control unit for the RV32I core. Sequences the program counter (drives its `Enable`, `Control` and `Target` inputs), and issues stall/flush controls to the IF/ID, ID/EX and EX/MEM registers. It handles start-up, load-use interlock, data-memory wait freeze, taken-branch/jump redirect and ECALL halt with pipeline drain. It also keeps cycle, stall and flush performance counters.

## Interface
- `DRAIN_CYCLES`, 3, cycles after ECALL leaves ID before `Halted` asserts (EX, MEM, WB).
- `CNT_W`, 32, performance counter width.

Ports:
- `Clk` in 1: core clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: pulse that leaves IDLE and begins fetching.
- `Id_rs1`, `Id_rs2` in 5: source registers of the instruction in ID.
- `Id_uses_rs1`, `Id_uses_rs2` in 1: the instruction in ID actually reads that source.
- `Id_ecall` in 1: the instruction in ID is ECALL or EBREAK.
- `Ex_rd` in 5: destination register of the instruction in EX.
- `Ex_mem_read` in 1: the instruction in EX is a load.
- `Ex_redirect` in 1: branch taken, or JAL/JALR, resolved in EX.
- `Ex_target` in 32: absolute redirect address from EX.
- `Mem_stall` in 1: data memory not ready; freeze the whole pipeline.
- `Pc` in 32: current PC value.
- `Pc_enable` out 1: drives the PC `Enable` input.
- `Pc_control` out 1: drives the PC `Control` input (1 = add `Pc_target`, 0 = add 4).
- `Pc_target` out 32: relative offset to the PC.
- `IfId_enable`, `IdEx_enable`, `ExMem_enable` out 1: pipeline register load enables.
- `IfId_flush`, `IdEx_flush` out 1: insert a bubble (NOP) at the next edge.
- `Halted` out 1: core stopped after ECALL.
- `Cycle_count`, `Stall_count`, `Flush_count` out CNT_W: performance counters.

## Operation
FSM states:
- **IDLE** (reset state):
  - Outputs: `Pc_enable`=0, both flushes=1, all enables=1, `Pc_control`=0.
  - `Start` → RUN.
- **RUN**: per-cycle priority, highest first.
  1. **Freeze** (`Mem_stall`): all enables 0, flushes 0, `Pc_enable`=0. A pending redirect or hazard is held by upstream stages and re-evaluated next cycle.
  2. **Redirect** (`Ex_redirect`):
     - `Pc_enable`=1, `Pc_control`=1.
     - `Pc_target` = `Ex_target` − `Pc` (mod 2^32), so the next `Pc` equals `Ex_target`.
     - `IfId_flush`=1, `IdEx_flush`=1.
     - `Id_ecall` is ignored this cycle because ID is on the wrong path.
  3. **Load-use**:
     - Condition: `Ex_mem_read` && `Ex_rd`≠0 && ((`Id_uses_rs1` && `Id_rs1`==`Ex_rd`) || (`Id_uses_rs2` && `Id_rs2`==`Ex_rd`)).
     - Response: `Pc_enable`=0, `IfId_enable`=0, `IdEx_flush`=1, for exactly one cycle per occurrence.
  4. **ECALL** (`Id_ecall`):
     - `Pc_enable`=0, `IfId_flush`=1. The ECALL advances to EX.
     - Load the drain counter with `DRAIN_CYCLES`−1; next state DRAIN.
  5. **Normal**: `Pc_enable`=1, `Pc_control`=0, all enables 1, flushes 0.
- **DRAIN**:
  - Outputs: `Pc_enable`=0, `IfId_flush`=1. The counter decrements only on non-frozen cycles.
  - Counter = 0 on a non-frozen cycle → HALT.
  - `Ex_redirect` from an older instruction cancels the drain: apply the redirect outputs, then RUN.
- **HALT**:
  - `Halted`=1, `Pc_enable`=0, all enables 0.
  - Leave only via `Reset`; `Start` is ignored.
- Outside RUN the `Pc_target` output is 0, and `Pc_control`=0 except for a redirect in DRAIN.
- Counters:
  - `Cycle_count` +1 per cycle in RUN/DRAIN.
  - `Stall_count` +1 per RUN cycle with a freeze or load-use.
  - `Flush_count` +1 per accepted redirect.
  - All counters saturate at all-ones.

## Timing
- All control outputs are combinational from the state and current inputs; they act at the next `Clk` edge. Redirect takes effect with zero added latency, at a fixed penalty of 2 bubbles.
- On `Reset` low, immediately:
  - State IDLE, drain counter 0, `Halted`=0, all counters 0.
  - `Pc_enable`=0, `Pc_control`=0, `Pc_target`=0.
  - `IfId_flush`=`IdEx_flush`=1, all enables 1.
- `Reset` asserted mid-drain or in HALT returns to IDLE in the same cycle; it is asynchronous.
- `Start` arriving in the same cycle as `Reset` deassertion is ignored. `Start` in RUN or DRAIN is ignored.
- `Mem_stall` together with `Ex_redirect`: freeze wins and no counter other than `Cycle_count`/`Stall_count` changes.
- Load-use together with `Id_ecall`: load-use wins; the ECALL is taken the following cycle.

## Structure
- Shared package `rv32_ctrl_pkg`: state enum (IDLE, RUN, DRAIN, HALT), `NOP_INSTR` constant, default `DRAIN_CYCLES`.
- One sub-module, `hazard_detect`: the combinational load-use compare. The FSM, target subtraction and counters stay in `pipeline_sequencer`.

## Test plan
- **Reset/start**:
  - `Reset` low → all outputs at the reset values above.
  - Release, hold 5 cycles → `Pc_enable` stays 0.
  - `Start` pulse → `Pc_enable`=1 from the next cycle.
- **Redirect**: `Pc`=0x100, `Ex_redirect`=1, `Ex_target`=0x40 → `Pc_control`=1, `Pc_target`=0xFFFFFF40, both flushes=1, `Flush_count`=1.
- **Load-use**:
  - `Ex_mem_read`=1, `Ex_rd`=5, `Id_rs2`=5, `Id_uses_rs2`=1 → one cycle of `Pc_enable`=0, `IfId_enable`=0, `IdEx_flush`=1.
  - Same with `Ex_rd`=0 → no stall.
- **Freeze**: `Mem_stall` held 3 cycles while `Ex_redirect`=1 → all enables 0 for 3 cycles, `Stall_count`=3; the redirect is applied in the 4th cycle.
- **ECALL drain**: `Id_ecall`=1 with no hazard → `Halted` asserts exactly `DRAIN_CYCLES` cycles later; a `Mem_stall` cycle during the drain delays it by 1.
- **Wrong-path ECALL**:
  - `Id_ecall` and `Ex_redirect` in the same cycle → redirect is taken, no drain.
  - `Ex_redirect` during DRAIN → state returns to RUN and `Halted` never asserts.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared control definitions for the RV32I pipeline sequencer.
package rv32_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StHalt
   } seq_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // EX, MEM and WB still have to retire after an ECALL leaves ID.
   localparam int unsigned DefaultDrainCycles = 3;

   localparam logic [4:0] RegZero = 5'd0;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Control bus between the pipeline sequencer and the datapath stages.
interface pipeline_sequencer_if #(
   parameter int unsigned CNT_W = 32
);

   // Datapath status into the sequencer
   logic             Start;
   logic [4:0]       Id_rs1;
   logic [4:0]       Id_rs2;
   logic             Id_uses_rs1;
   logic             Id_uses_rs2;
   logic             Id_ecall;
   logic [4:0]       Ex_rd;
   logic             Ex_mem_read;
   logic             Ex_redirect;
   logic [31:0]      Ex_target;
   logic             Mem_stall;
   logic [31:0]      Pc;

   // Sequencer controls out to the PC and pipeline registers
   logic             Pc_enable;
   logic             Pc_control;
   logic [31:0]      Pc_target;
   logic             IfId_enable;
   logic             IdEx_enable;
   logic             ExMem_enable;
   logic             IfId_flush;
   logic             IdEx_flush;
   logic             Halted;
   logic [CNT_W-1:0] Cycle_count;
   logic [CNT_W-1:0] Stall_count;
   logic [CNT_W-1:0] Flush_count;

   modport master (
      input  Start, Id_rs1, Id_rs2, Id_uses_rs1, Id_uses_rs2, Id_ecall,
             Ex_rd, Ex_mem_read, Ex_redirect, Ex_target, Mem_stall, Pc,
      output Pc_enable, Pc_control, Pc_target, IfId_enable, IdEx_enable,
             ExMem_enable, IfId_flush, IdEx_flush, Halted,
             Cycle_count, Stall_count, Flush_count
   );

   modport slave (
      output Start, Id_rs1, Id_rs2, Id_uses_rs1, Id_uses_rs2, Id_ecall,
             Ex_rd, Ex_mem_read, Ex_redirect, Ex_target, Mem_stall, Pc,
      input  Pc_enable, Pc_control, Pc_target, IfId_enable, IdEx_enable,
             ExMem_enable, IfId_flush, IdEx_flush, Halted,
             Cycle_count, Stall_count, Flush_count
   );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of ID.
module hazard_detect
   import rv32_ctrl_pkg::*;
(
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is never a real dependency, so a load into x0 cannot stall
   always_comb begin
      rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
      rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
      load_use_o = ex_mem_read_i && (ex_rd_i != RegZero) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control unit: start-up, interlocks, redirects, ECALL drain and perf counters.
module pipeline_sequencer
   import rv32_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DefaultDrainCycles,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                 Clk,
   input  logic                 Reset,
   pipeline_sequencer_if.master bus
);

   localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

   seq_state_e        state_q, state_d;
   logic [DrainW-1:0] drain_q, drain_d;
   // Low for the first edge after reset so a Start coincident with release is dropped
   logic              armed_q;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;

   logic        load_use;
   logic [31:0] redirect_tgt;
   logic        cyc_inc, stl_inc, fls_inc;
   logic        pc_en, pc_ctl, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl;
   logic [31:0] pc_tgt;

   hazard_detect u_hazard (
      .ex_mem_read_i (bus.Ex_mem_read),
      .ex_rd_i       (bus.Ex_rd),
      .id_rs1_i      (bus.Id_rs1),
      .id_rs2_i      (bus.Id_rs2),
      .id_uses_rs1_i (bus.Id_uses_rs1),
      .id_uses_rs2_i (bus.Id_uses_rs2),
      .load_use_o    (load_use)
   );

   // PC adds the offset, so convert the absolute target into a relative one
   assign redirect_tgt = bus.Ex_target - bus.Pc;

   // Next-state and control outputs, priority freeze > redirect > load-use > ecall
   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      pc_en    = 1'b0;
      pc_ctl   = 1'b0;
      pc_tgt   = '0;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      ifid_fl  = 1'b0;
      idex_fl  = 1'b0;
      cyc_inc  = 1'b0;
      stl_inc  = 1'b0;
      fls_inc  = 1'b0;
      unique case (state_q)
         StIdle: begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
            if (bus.Start && armed_q) state_d = StRun;
         end
         StRun: begin
            cyc_inc = 1'b1;
            if (bus.Mem_stall) begin
               ifid_en  = 1'b0;
               idex_en  = 1'b0;
               exmem_en = 1'b0;
               stl_inc  = 1'b1;
            end else if (bus.Ex_redirect) begin
               pc_en   = 1'b1;
               pc_ctl  = 1'b1;
               pc_tgt  = redirect_tgt;
               ifid_fl = 1'b1;
               idex_fl = 1'b1;
               fls_inc = 1'b1;
            end else if (load_use) begin
               ifid_en = 1'b0;
               idex_fl = 1'b1;
               stl_inc = 1'b1;
            end else if (bus.Id_ecall) begin
               ifid_fl = 1'b1;
               drain_d = DrainLoad;
               state_d = StDrain;
            end else begin
               pc_en = 1'b1;
            end
         end
         StDrain: begin
            cyc_inc = 1'b1;
            ifid_fl = 1'b1;
            if (bus.Mem_stall) begin
               ifid_en  = 1'b0;
               idex_en  = 1'b0;
               exmem_en = 1'b0;
            end else if (bus.Ex_redirect) begin
               // An older branch in EX makes the ECALL wrong-path: abandon the drain
               pc_en   = 1'b1;
               pc_ctl  = 1'b1;
               pc_tgt  = redirect_tgt;
               idex_fl = 1'b1;
               fls_inc = 1'b1;
               state_d = StRun;
            end else if (drain_q == '0) begin
               state_d = StHalt;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         StHalt: begin
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Saturating performance counters
   always_comb begin
      cycle_d = (cyc_inc && (cycle_q != '1)) ? cycle_q + CNT_W'(1) : cycle_q;
      stall_d = (stl_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
      flush_d = (fls_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
   end

   // State, drain counter and counters with asynchronous active-low reset
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         drain_q <= '0;
         armed_q <= 1'b0;
         cycle_q <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         armed_q <= 1'b1;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign bus.Pc_enable    = pc_en;
   assign bus.Pc_control   = pc_ctl;
   assign bus.Pc_target    = pc_tgt;
   assign bus.IfId_enable  = ifid_en;
   assign bus.IdEx_enable  = idex_en;
   assign bus.ExMem_enable = exmem_en;
   assign bus.IfId_flush   = ifid_fl;
   assign bus.IdEx_flush   = idex_fl;
   assign bus.Halted       = (state_q == StHalt);
   assign bus.Cycle_count  = cycle_q;
   assign bus.Stall_count  = stall_q;
   assign bus.Flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed plan items plus random traffic.
module tb_pipeline_sequencer;

   localparam int unsigned DRAIN = 3;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_HALT  = 3;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   pipeline_sequencer_if #(.CNT_W(32)) bus ();

   pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic        start, stall, redir, ecall, mem_read, uses1, uses2;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] tgt, pc;
   } in_t;

   typedef struct packed {
      logic        pc_en, pc_ctl;
      logic [31:0] pc_tgt;
      logic        ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, halted;
      logic [31:0] cyc, stl, fls;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: what mode the core is in and what has been counted
   int          m_mode, m_drain, n_mode, n_drain;
   bit          m_armed;
   logic [31:0] m_cyc, m_stl, m_fls, n_cyc, n_stl, n_fls;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic in_t quiet();
      in_t i;
      i = '0;
      return i;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_drain = 0; m_armed = 1'b0;
      m_cyc = '0; m_stl = '0; m_fls = '0;
   endtask

   // Apply inputs, predict this cycle's outputs and the model's next state
   task automatic drive(input in_t i);
      exp_t e;
      bit   lu;
      bus.Start = i.start; bus.Mem_stall = i.stall; bus.Ex_redirect = i.redir;
      bus.Id_ecall = i.ecall; bus.Ex_mem_read = i.mem_read; bus.Id_uses_rs1 = i.uses1;
      bus.Id_uses_rs2 = i.uses2; bus.Id_rs1 = i.rs1; bus.Id_rs2 = i.rs2; bus.Ex_rd = i.rd;
      bus.Ex_target = i.tgt; bus.Pc = i.pc;
      lu = i.mem_read && (i.rd != 0) &&
           ((i.uses1 && i.rs1 == i.rd) || (i.uses2 && i.rs2 == i.rd));
      e = '0;
      e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls;
      e.halted = (m_mode == M_HALT);
      n_mode = m_mode; n_drain = m_drain; n_cyc = m_cyc; n_stl = m_stl; n_fls = m_fls;
      case (m_mode)
         M_IDLE: begin
            e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; e.ifid_fl = 1; e.idex_fl = 1;
            if (i.start && m_armed) n_mode = M_RUN;
         end
         M_RUN: begin
            n_cyc = sat(m_cyc);
            if (i.stall) begin
               n_stl = sat(m_stl);
            end else if (i.redir) begin
               e.pc_en = 1; e.pc_ctl = 1; e.pc_tgt = i.tgt - i.pc;
               e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; e.ifid_fl = 1; e.idex_fl = 1;
               n_fls = sat(m_fls);
            end else if (lu) begin
               e.idex_en = 1; e.exmem_en = 1; e.idex_fl = 1;
               n_stl = sat(m_stl);
            end else if (i.ecall) begin
               e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1; e.ifid_fl = 1;
               n_mode = M_DRAIN; n_drain = DRAIN - 1;
            end else begin
               e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
            end
         end
         M_DRAIN: begin
            n_cyc = sat(m_cyc);
            e.ifid_fl = 1;
            if (!i.stall) begin
               e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
               if (i.redir) begin
                  e.pc_en = 1; e.pc_ctl = 1; e.pc_tgt = i.tgt - i.pc; e.idex_fl = 1;
                  n_fls = sat(m_fls); n_mode = M_RUN;
               end else if (m_drain == 0) begin
                  n_mode = M_HALT;
               end else begin
                  n_drain = m_drain - 1;
               end
            end
         end
         default: ;
      endcase
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
      m_mode = n_mode; m_drain = n_drain; m_armed = 1'b1;
      m_cyc = n_cyc; m_stl = n_stl; m_fls = n_fls;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      #1;
      check("rst_pc_enable", 32'(bus.Pc_enable), 0);
      check("rst_pc_control", 32'(bus.Pc_control), 0);
      check("rst_pc_target", bus.Pc_target, 0);
      check("rst_flushes", {30'd0, bus.IfId_flush, bus.IdEx_flush}, 3);
      check("rst_enables", {29'd0, bus.IfId_enable, bus.IdEx_enable, bus.ExMem_enable}, 7);
      check("rst_halted", 32'(bus.Halted), 0);
      check("rst_counters", bus.Cycle_count | bus.Stall_count | bus.Flush_count, 0);
      q.delete();
      model_reset();
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 1'b1;
   endtask

   task automatic start_run();
      in_t i;
      drive(quiet()); tick();
      i = quiet(); i.start = 1; drive(i); tick();
   endtask

   // Monitor: compare every predicted cycle away from the active edge
   always @(negedge Clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         check("pc_enable", 32'(bus.Pc_enable), 32'(mon_e.pc_en));
         check("pc_control", 32'(bus.Pc_control), 32'(mon_e.pc_ctl));
         check("pc_target", bus.Pc_target, mon_e.pc_tgt);
         check("ifid_enable", 32'(bus.IfId_enable), 32'(mon_e.ifid_en));
         check("idex_enable", 32'(bus.IdEx_enable), 32'(mon_e.idex_en));
         check("exmem_enable", 32'(bus.ExMem_enable), 32'(mon_e.exmem_en));
         check("ifid_flush", 32'(bus.IfId_flush), 32'(mon_e.ifid_fl));
         check("idex_flush", 32'(bus.IdEx_flush), 32'(mon_e.idex_fl));
         check("halted", 32'(bus.Halted), 32'(mon_e.halted));
         check("cycle_count", bus.Cycle_count, mon_e.cyc);
         check("stall_count", bus.Stall_count, mon_e.stl);
         check("flush_count", bus.Flush_count, mon_e.fls);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t         i;
      int          k;
      logic [31:0] stl0, fls0;
      bit          seen_halt;

      bus.Start = 0; bus.Mem_stall = 0; bus.Ex_redirect = 0; bus.Id_ecall = 0;
      bus.Ex_mem_read = 0; bus.Id_uses_rs1 = 0; bus.Id_uses_rs2 = 0; bus.Id_rs1 = 0;
      bus.Id_rs2 = 0; bus.Ex_rd = 0; bus.Ex_target = 0; bus.Pc = 0;
      #2;
      do_reset();

      // Start on the first edge after release is dropped, then idle for 5 cycles
      i = quiet(); i.start = 1; drive(i); tick();
      for (int c = 0; c < 5; c++) begin
         drive(quiet()); #1;
         check("idle_pc_enable", 32'(bus.Pc_enable), 0);
         tick();
      end
      i = quiet(); i.start = 1; drive(i); tick();
      drive(quiet()); #1;
      check("start_pc_enable", 32'(bus.Pc_enable), 1);
      tick();

      // Redirect to 0x40 from 0x100
      i = quiet(); i.pc = 32'h100; i.redir = 1; i.tgt = 32'h40; drive(i); #1;
      check("redir_pc_control", 32'(bus.Pc_control), 1);
      check("redir_pc_target", bus.Pc_target, 32'hFFFF_FF40);
      check("redir_flushes", {30'd0, bus.IfId_flush, bus.IdEx_flush}, 3);
      tick();
      drive(quiet()); #1;
      check("redir_flush_count", bus.Flush_count, 1);
      tick();

      // Load-use on rs2, then the same with rd = x0
      i = quiet(); i.mem_read = 1; i.rd = 5; i.rs2 = 5; i.uses2 = 1; drive(i); #1;
      check("lu_pc_enable", 32'(bus.Pc_enable), 0);
      check("lu_ifid_enable", 32'(bus.IfId_enable), 0);
      check("lu_idex_flush", 32'(bus.IdEx_flush), 1);
      tick();
      drive(quiet()); #1;
      check("lu_one_cycle", 32'(bus.Pc_enable), 1);
      tick();
      i.rd = 0; i.rs2 = 0; drive(i); #1;
      check("lu_x0_no_stall", {30'd0, bus.Pc_enable, bus.IfId_enable}, 3);
      tick();

      // Freeze for 3 cycles with a redirect pending, applied on the 4th
      stl0 = m_stl; fls0 = m_fls;
      i = quiet(); i.stall = 1; i.redir = 1; i.pc = 32'h80; i.tgt = 32'h200;
      for (int c = 0; c < 3; c++) begin
         drive(i); #1;
         check("freeze_enables",
               {28'd0, bus.Pc_enable, bus.IfId_enable, bus.IdEx_enable, bus.ExMem_enable}, 0);
         tick();
      end
      i.stall = 0; drive(i); #1;
      check("freeze_stall_count", bus.Stall_count, stl0 + 3);
      check("freeze_flush_count", bus.Flush_count, fls0);
      check("freeze_then_redirect", bus.Pc_target, 32'h180);
      tick();

      // ECALL drain latency, plain and with one frozen drain cycle
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            do_reset();
            start_run();
         end
         i = quiet(); i.ecall = 1; drive(i); tick();
         k = 1;
         while (k <= 20) begin
            i = quiet(); i.stall = (pass == 1 && k == 1); drive(i); tick();
            if (bus.Halted) break;
            k++;
         end
         check(pass == 0 ? "halt_latency" : "halt_latency_stalled", k, DRAIN + pass);
      end
      // Start is ignored in HALT
      i = quiet(); i.start = 1; drive(i); tick();
      check("halt_sticky", 32'(bus.Halted), 1);

      // Wrong-path ECALL alongside a redirect: no drain
      do_reset();
      start_run();
      i = quiet(); i.ecall = 1; i.redir = 1; i.tgt = 32'h20; i.pc = 32'h10; drive(i); tick();
      drive(quiet()); #1;
      check("wrongpath_no_drain", 32'(bus.Pc_enable), 1);
      tick();

      // Redirect during DRAIN cancels the halt
      i = quiet(); i.ecall = 1; drive(i); tick();
      drive(quiet()); tick();
      i = quiet(); i.redir = 1; i.tgt = 32'h300; i.pc = 32'h24; drive(i); tick();
      seen_halt = 0;
      for (int c = 0; c < 8; c++) begin
         drive(quiet()); tick();
         seen_halt |= bus.Halted;
      end
      check("drain_cancel_no_halt", 32'(seen_halt), 0);

      // Load-use beats ECALL; ECALL follows next cycle
      i = quiet(); i.ecall = 1; i.mem_read = 1; i.rd = 7; i.rs1 = 7; i.uses1 = 1;
      drive(i); #1;
      check("lu_over_ecall", 32'(bus.IfId_enable), 0);
      tick();
      i = quiet(); i.ecall = 1; drive(i); #1;
      check("ecall_after_lu", {30'd0, bus.IfId_flush, bus.IfId_enable}, 3);
      tick();

      // Random traffic against the model
      for (int n = 0; n < 800; n++) begin
         if (m_mode == M_HALT || $urandom_range(0, 99) == 0) begin
            do_reset();
            start_run();
         end
         i = quiet();
         i.start    = ($urandom_range(0, 9) == 0);
         i.stall    = ($urandom_range(0, 99) < 15);
         i.redir    = ($urandom_range(0, 99) < 12);
         i.ecall    = ($urandom_range(0, 99) < 6);
         i.mem_read = ($urandom_range(0, 99) < 40);
         i.uses1    = 1'($urandom_range(0, 1));
         i.uses2    = 1'($urandom_range(0, 1));
         i.rs1      = 5'($urandom_range(0, 3));
         i.rs2      = 5'($urandom_range(0, 3));
         i.rd       = 5'($urandom_range(0, 3));
         i.tgt      = $urandom;
         i.pc       = $urandom;
         drive(i);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
